// File: rtl/hub75_bcm_driver_if.sv
// Pixel fetch bus between the HUB75 BCM driver (master) and the painter (slave).
// Request strobe with row/column/plane; colour words return a fixed latency later.
interface hub75_bcm_driver_if #(
  parameter int ADDR_BITS = 5,
  parameter int COL_BITS  = 6,
  parameter int PLANES    = 8
) ();
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;

  logic                 pix_req;
  logic [ADDR_BITS-1:0] pix_row;
  logic [COL_BITS-1:0]  pix_col;
  logic [PW-1:0]        pix_plane;
  logic [3*PLANES-1:0]  pix_rgb0;
  logic [3*PLANES-1:0]  pix_rgb1;

  modport master (
    output pix_req, pix_row, pix_col, pix_plane,
    input  pix_rgb0, pix_rgb1
  );

  modport slave (
    input  pix_req, pix_row, pix_col, pix_plane,
    output pix_rgb0, pix_rgb1
  );
endinterface

// File: rtl/hub75_bcm_driver.sv
// Dual-scan HUB75 driver with BCM colour depth; shifts the next plane while the last one is lit.
// Optional HUB75_BRIGHTNESS_EN adds brightness_i, scaling on-time while keeping the BCM period.
module hub75_bcm_driver #(
  parameter int ADDR_BITS   = 5,
  parameter int COL_BITS    = 6,
  parameter int PLANES      = 8,
  parameter int LSB_CYCLES  = 16,
  parameter int PIX_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hub75_bcm_driver_if.master   pix,
  output logic [2:0]           led_rgb0_o,
  output logic [2:0]           led_rgb1_o,
  output logic [ADDR_BITS-1:0] led_addr_o,
  output logic                 led_blank_o,
  output logic                 led_latch_o,
  output logic                 led_sclk_o,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]           brightness_i,
`endif
  output logic                 frame_start_o
);
  localparam int PW    = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int TW    = $clog2(LSB_CYCLES << (PLANES - 1)) + 1;
  localparam int CW    = COL_BITS + 3;
  localparam int COLS2 = 2 * (1 << COL_BITS);
  localparam int LAST  = COLS2 + PIX_LATENCY + 1;

  typedef enum logic [2:0] {S_SHIFT, S_WAIT, S_BLANK, S_LATCH, S_UNBLANK} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [ADDR_BITS-1:0] row_q, addr_q;
  logic [COL_BITS-1:0]  col_q;
  logic [PW-1:0]        plane_q;
  logic [TW-1:0]        timer_q, timer_d, on_q, on_d, full_load, on_load;
  logic [PIX_LATENCY:0] req_pipe_q;
  logic                 pix_req_q, frame_q, blank_q, latch_q, sclk_q;
  logic [2:0]           rgb0_q, rgb1_q, bits0, bits1;

  function automatic logic [2:0] plane_bits(input logic [3*PLANES-1:0] rgb,
                                            input logic [PW-1:0] p);
    logic [2:0] b;
    b = '0;
    for (int i = 0; i < PLANES; i++)
      if (p == PW'(i)) b = {rgb[2*PLANES+i], rgb[PLANES+i], rgb[i]};
    return b;
  endfunction

  // timer_q sets the BCM period, on_q the lit part of it; they differ only when dimmed
  always_comb begin
    timer_d   = (timer_q == '0) ? '0 : timer_q - 1'b1;
    on_d      = (on_q == '0) ? '0 : on_q - 1'b1;
    full_load = TW'(LSB_CYCLES) << plane_q;
`ifdef HUB75_BRIGHTNESS_EN
    on_load   = TW'(({8'd0, full_load} * {{TW{1'b0}}, brightness_i}) >> 8);
`else
    on_load   = full_load;
`endif
    bits0     = plane_bits(pix.pix_rgb0, plane_q);
    bits1     = plane_bits(pix.pix_rgb1, plane_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SHIFT;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      plane_q    <= '0;
      addr_q     <= '0;
      timer_q    <= '0;
      on_q       <= '0;
      req_pipe_q <= '0;
      pix_req_q  <= 1'b0;
      frame_q    <= 1'b0;
      blank_q    <= 1'b1;
      latch_q    <= 1'b0;
      sclk_q     <= 1'b0;
      rgb0_q     <= '0;
      rgb1_q     <= '0;
    end else begin
      req_pipe_q <= {req_pipe_q[PIX_LATENCY-1:0], pix_req_q};
      if (req_pipe_q[PIX_LATENCY-1]) begin
        rgb0_q <= bits0;
        rgb1_q <= bits1;
      end
      sclk_q    <= req_pipe_q[PIX_LATENCY];
      timer_q   <= timer_d;
      on_q      <= on_d;
      blank_q   <= (on_d == '0);
      pix_req_q <= 1'b0;
      frame_q   <= 1'b0;
      case (state_q)
        S_SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q < CW'(COLS2) && !cnt_q[0]) begin
            pix_req_q <= 1'b1;
            col_q     <= cnt_q[COL_BITS:1];
            frame_q   <= (cnt_q == '0) && (row_q == '0) && (plane_q == '0);
          end
          if (cnt_q == CW'(LAST)) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        S_WAIT:
          if (timer_q == '0) state_q <= S_BLANK;
        S_BLANK: begin
          latch_q <= 1'b1;
          addr_q  <= row_q;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          latch_q <= 1'b0;
          blank_q <= (on_load == '0);
          timer_q <= full_load;
          on_q    <= on_load;
          if (plane_q == PW'(PLANES - 1)) begin
            plane_q <= '0;
            row_q   <= row_q + 1'b1;
          end else begin
            plane_q <= plane_q + 1'b1;
          end
          state_q <= S_UNBLANK;
        end
        S_UNBLANK: state_q <= S_SHIFT;
        default:   state_q <= S_SHIFT;
      endcase
    end
  end

  assign pix.pix_req    = pix_req_q;
  assign pix.pix_row    = row_q;
  assign pix.pix_col    = col_q;
  assign pix.pix_plane  = plane_q;
  assign led_rgb0_o     = rgb0_q;
  assign led_rgb1_o     = rgb1_q;
  assign led_addr_o     = addr_q;
  assign led_blank_o    = blank_q;
  assign led_latch_o    = latch_q;
  assign led_sclk_o     = sclk_q;
  assign frame_start_o  = frame_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench: small 4x4-column panel with 2 planes, plus a 3-plane unit for BCM on-times.
module tb_hub75_bcm_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  int total = 0, bad = 0;

  hub75_bcm_driver_if #(.ADDR_BITS(2), .COL_BITS(2), .PLANES(2)) if_a ();
  hub75_bcm_driver_if #(.ADDR_BITS(2), .COL_BITS(2), .PLANES(3)) if_b ();

  logic [2:0] rgb0_a, rgb1_a, rgb0_b, rgb1_b;
  logic [1:0] addr_a, addr_b;
  logic blank_a, latch_a, sclk_a, frame_a, blank_b, latch_b, sclk_b, frame_b;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] br_a = 8'd255, br_b = 8'd128;
`endif

  hub75_bcm_driver #(.ADDR_BITS(2), .COL_BITS(2), .PLANES(2), .LSB_CYCLES(4), .PIX_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a), .pix(if_a),
    .led_rgb0_o(rgb0_a), .led_rgb1_o(rgb1_a), .led_addr_o(addr_a), .led_blank_o(blank_a),
    .led_latch_o(latch_a), .led_sclk_o(sclk_a),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness_i(br_a),
`endif
    .frame_start_o(frame_a));

  hub75_bcm_driver #(.ADDR_BITS(2), .COL_BITS(2), .PLANES(3), .LSB_CYCLES(64), .PIX_LATENCY(1)) dut_b (
    .clk(clk), .reset(rst_b), .pix(if_b),
    .led_rgb0_o(rgb0_b), .led_rgb1_o(rgb1_b), .led_addr_o(addr_b), .led_blank_o(blank_b),
    .led_latch_o(latch_b), .led_sclk_o(sclk_b),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness_i(br_b),
`endif
    .frame_start_o(frame_b));

  // painter: one-cycle latency, zero outside the valid slot
  always @(posedge clk) begin
    if_a.pix_rgb0 <= !if_a.pix_req ? 6'd0 : (if_a.pix_col == 2'd3 ? 6'b011000 : 6'b100111);
    if_a.pix_rgb1 <= if_a.pix_req ? 6'b110100 : 6'd0;
    if_b.pix_rgb0 <= if_b.pix_req ? 9'h1ff : 9'd0;
    if_b.pix_rgb1 <= 9'd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int t_a(input int p);
`ifdef HUB75_BRIGHTNESS_EN
    return ((4 << p) * 255) >> 8;
`else
    return 4 << p;
`endif
  endfunction

  // row-plane n starts shifting at cycle 15n; latch at 15n+13; lit from 15n+14
  function automatic logic exp_blank_a(input int k);
    for (int n = 0; n * 15 <= k; n++)
      if (k >= 15 * n + 14 && k <= 15 * n + 13 + t_a(n % 2)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_a(input int k);
    int m, n, j, p;
    logic req_e, sclk_e;
    logic [2:0] e0, e1;
    m = k % 15;
    n = k / 15;
    p = n % 2;
    req_e  = (m % 2 == 1) && (m <= 7);
    sclk_e = (m >= 4) && (m <= 10) && (m % 2 == 0);
    check("pix_req", 32'(if_a.pix_req), 32'(req_e));
    if (req_e) begin
      check("pix_col", 32'(if_a.pix_col), (m - 1) / 2);
      check("pix_row", 32'(if_a.pix_row), (n / 2) % 4);
      check("pix_plane", 32'(if_a.pix_plane), p);
    end
    check("frame_start", 32'(frame_a), 32'(k % 120 == 1));
    check("led_sclk", 32'(sclk_a), 32'(sclk_e));
    if (sclk_e) begin
      j  = (m - 4) / 2;
      e0 = (j == 3) ? ((p == 0) ? 3'b100 : 3'b010) : ((p == 0) ? 3'b011 : 3'b101);
      e1 = (p == 0) ? 3'b110 : 3'b100;
      check("led_rgb0", 32'(rgb0_a), 32'(e0));
      check("led_rgb1", 32'(rgb1_a), 32'(e1));
    end
    check("led_latch", 32'(latch_a), 32'(m == 13));
    check("led_blank", 32'(blank_a), 32'(exp_blank_a(k)));
    check("led_addr", 32'(addr_a), (k < 13) ? 0 : (((k - 13) / 15) / 2) % 4);
  endtask

  task automatic run_a(input int kmax);
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) tick();
      check_a(k);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_blank"}, 32'(blank_a), 1);
    check({tag, "_latch"}, 32'(latch_a), 0);
    check({tag, "_sclk"}, 32'(sclk_a), 0);
    check({tag, "_req"}, 32'(if_a.pix_req), 0);
    check({tag, "_frame"}, 32'(frame_a), 0);
    check({tag, "_addr"}, 32'(addr_a), 0);
    check({tag, "_rgb"}, 32'({rgb0_a, rgb1_a}), 0);
  endtask

  initial begin
    int lat[4];
    int run[3];
    int nl, nr, cur, lit;
    lat = '{default: 0};
    run = '{default: 0};
    nl = 0; nr = 0; cur = 0; lit = 0;

    repeat (3) tick();
    check_reset_a("rst");

    // two full frames plus part of a third, reset hits during column 2 of row-plane 20
    rst_a = 1'b0;
    run_a(305);
    rst_a = 1'b1;
    tick();
    check_reset_a("midrst");
    rst_a = 1'b0;
    run_a(30);

    // 3-plane unit: latch spacing and lit windows
    rst_b = 1'b0;
    for (int k = 0; k < 600 && nl < 4; k++) begin
      if (k > 0) tick();
      if (latch_b) begin
        lat[nl] = k;
        nl++;
      end
      if (!blank_b) cur++;
      else if (cur > 0) begin
        if (nr < 3) run[nr] = cur;
        nr++;
        cur = 0;
      end
    end
    check("b_first_latch", lat[0], 13);
    check("b_space0", lat[1] - lat[0], 67);
    check("b_space1", lat[2] - lat[1], 131);
    check("b_space2", lat[3] - lat[2], 259);
`ifdef HUB75_BRIGHTNESS_EN
    check("b_lit0", run[0], 32);
    check("b_lit1", run[1], 64);
    check("b_lit2", run[2], 128);
    br_b = 8'd0;
    cur = 0;
    for (int k = 0; k < 400 && !latch_b; k++) tick();
    check("b_latch_seen", 32'(latch_b), 1);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!blank_b) lit++;
    end
    check("b_dark", lit, 0);
`else
    check("b_lit0", run[0], 64);
    check("b_lit1", run[1], 128);
    check("b_lit2", run[2], 256);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
